// File: rtl/cv32e40p_rvfi_trace_sched.sv
// RVFI retirement FIFO that drains trace records over valid/ready, splitting dual-writeback
// instructions into one record per written register. Optional cycle stamp: CV32E40P_RVFI_TRACE_CYCLE_EN.
module cv32e40p_rvfi_trace_sched #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             rvfi_valid,
    input  logic [31:0]      rvfi_pc_rdata,
    input  logic [31:0]      rvfi_insn,
    input  logic [4:0]       rvfi_rd_addr0,
    input  logic [31:0]      rvfi_rd_wdata0,
    input  logic [4:0]       rvfi_rd_addr1,
    input  logic [31:0]      rvfi_rd_wdata1,
    output logic             trc_valid_o,
    input  logic             trc_ready_i,
    output logic [31:0]      trc_pc_o,
    output logic [31:0]      trc_insn_o,
    output logic [4:0]       trc_rd_addr_o,
    output logic [31:0]      trc_rd_wdata_o,
    output logic             trc_last_o,
`ifdef CV32E40P_RVFI_TRACE_CYCLE_EN
    output logic [31:0]      trc_cycle_o,
`endif
    output logic             full_o,
    output logic [CNT_W-1:0] retire_cnt_o,
    output logic [CNT_W-1:0] drop_cnt_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = (AW+1)'(1);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    typedef enum logic [1:0] {StIdle, StEmit0, StEmit1} state_e;

    state_e           state_q, state_d;
    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d, drop_cnt_q, drop_cnt_d;

    logic [31:0] pc_mem     [DEPTH];
    logic [31:0] insn_mem   [DEPTH];
    logic [4:0]  addr0_mem  [DEPTH];
    logic [31:0] wdata0_mem [DEPTH];
    logic [4:0]  addr1_mem  [DEPTH];
    logic [31:0] wdata1_mem [DEPTH];

`ifdef CV32E40P_RVFI_TRACE_CYCLE_EN
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] cycle_mem [DEPTH];
`endif

    logic [AW-1:0] waddr, raddr;
    logic          empty, full, push, pop, hs, need_two, remain;

    assign waddr    = wptr_q[AW-1:0];
    assign raddr    = rptr_q[AW-1:0];
    assign empty    = (wptr_q == rptr_q);
    assign full     = (wptr_q[AW] != rptr_q[AW]) && (waddr == raddr);
    // A full FIFO rejects the push even when the head pops in the same cycle.
    assign push     = rvfi_valid && !full;
    assign hs       = trc_valid_o && trc_ready_i;
    assign need_two = (addr1_mem[raddr] != 5'd0) && (addr1_mem[raddr] != addr0_mem[raddr]);
    assign pop      = hs && ((state_q == StEmit1) || !need_two);
    // Only entries already registered count; a same-edge push is seen from IDLE next cycle.
    assign remain   = ((rptr_q + PtrOne) != wptr_q);

    always_comb begin
        wptr_d       = push ? (wptr_q + PtrOne) : wptr_q;
        rptr_d       = pop ? (rptr_q + PtrOne) : rptr_q;
        retire_cnt_d = (push && (retire_cnt_q != '1)) ? (retire_cnt_q + CntOne) : retire_cnt_q;
        drop_cnt_d   = (rvfi_valid && full && (drop_cnt_q != '1)) ? (drop_cnt_q + CntOne)
                                                                   : drop_cnt_q;
        state_d      = state_q;
        case (state_q)
            StIdle:  if (!empty) state_d = StEmit0;
            StEmit0: if (trc_ready_i) begin
                if (need_two)    state_d = StEmit1;
                else if (remain) state_d = StEmit0;
                else             state_d = StIdle;
            end
            StEmit1: if (trc_ready_i) state_d = remain ? StEmit0 : StIdle;
            default: state_d = StIdle;
        endcase
    end

`ifdef CV32E40P_RVFI_TRACE_CYCLE_EN
    assign cycle_d = cycle_q + 32'd1;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            wptr_q       <= '0;
            rptr_q       <= '0;
            retire_cnt_q <= '0;
            drop_cnt_q   <= '0;
`ifdef CV32E40P_RVFI_TRACE_CYCLE_EN
            cycle_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            retire_cnt_q <= retire_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
`ifdef CV32E40P_RVFI_TRACE_CYCLE_EN
            cycle_q      <= cycle_d;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[waddr]     <= rvfi_pc_rdata;
            insn_mem[waddr]   <= rvfi_insn;
            addr0_mem[waddr]  <= rvfi_rd_addr0;
            wdata0_mem[waddr] <= rvfi_rd_wdata0;
            addr1_mem[waddr]  <= rvfi_rd_addr1;
            wdata1_mem[waddr] <= rvfi_rd_wdata1;
`ifdef CV32E40P_RVFI_TRACE_CYCLE_EN
            cycle_mem[waddr]  <= cycle_q;
`endif
        end
    end

    assign trc_valid_o = (state_q != StIdle);

    always_comb begin
        trc_pc_o       = '0;
        trc_insn_o     = '0;
        trc_rd_addr_o  = '0;
        trc_rd_wdata_o = '0;
        trc_last_o     = 1'b0;
`ifdef CV32E40P_RVFI_TRACE_CYCLE_EN
        trc_cycle_o    = '0;
`endif
        if (trc_valid_o) begin
            trc_pc_o   = pc_mem[raddr];
            trc_insn_o = insn_mem[raddr];
`ifdef CV32E40P_RVFI_TRACE_CYCLE_EN
            trc_cycle_o = cycle_mem[raddr];
`endif
            if (state_q == StEmit1) begin
                trc_rd_addr_o  = addr1_mem[raddr];
                trc_rd_wdata_o = wdata1_mem[raddr];
                trc_last_o     = 1'b1;
            end else begin
                trc_rd_addr_o  = addr0_mem[raddr];
                trc_rd_wdata_o = wdata0_mem[raddr];
                trc_last_o     = !need_two;
            end
        end
    end

    assign full_o       = full;
    assign retire_cnt_o = retire_cnt_q;
    assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_cv32e40p_rvfi_trace_sched.sv
// Self-checking bench: table vectors, hand-written corner sequences and random traffic
// compared against a queue-of-entries reference model.
module tb_cv32e40p_rvfi_trace_sched;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 16;
    localparam int CntMax = (1 << CNT_W) - 1;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic             rst_ni;
    logic             rvfi_valid;
    logic [31:0]      rvfi_pc_rdata, rvfi_insn, rvfi_rd_wdata0, rvfi_rd_wdata1;
    logic [4:0]       rvfi_rd_addr0, rvfi_rd_addr1;
    logic             trc_valid_o, trc_ready_i, trc_last_o, full_o;
    logic [31:0]      trc_pc_o, trc_insn_o, trc_rd_wdata_o;
    logic [4:0]       trc_rd_addr_o;
    logic [CNT_W-1:0] retire_cnt_o, drop_cnt_o;
`ifdef CV32E40P_RVFI_TRACE_CYCLE_EN
    logic [31:0]      trc_cycle_o;
`endif

    cv32e40p_rvfi_trace_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .rvfi_valid    (rvfi_valid),
        .rvfi_pc_rdata (rvfi_pc_rdata),
        .rvfi_insn     (rvfi_insn),
        .rvfi_rd_addr0 (rvfi_rd_addr0),
        .rvfi_rd_wdata0(rvfi_rd_wdata0),
        .rvfi_rd_addr1 (rvfi_rd_addr1),
        .rvfi_rd_wdata1(rvfi_rd_wdata1),
        .trc_valid_o   (trc_valid_o),
        .trc_ready_i   (trc_ready_i),
        .trc_pc_o      (trc_pc_o),
        .trc_insn_o    (trc_insn_o),
        .trc_rd_addr_o (trc_rd_addr_o),
        .trc_rd_wdata_o(trc_rd_wdata_o),
        .trc_last_o    (trc_last_o),
`ifdef CV32E40P_RVFI_TRACE_CYCLE_EN
        .trc_cycle_o   (trc_cycle_o),
`endif
        .full_o        (full_o),
        .retire_cnt_o  (retire_cnt_o),
        .drop_cnt_o    (drop_cnt_o)
    );

    // Reference model: queued instructions, each tagged with the edge count before its push.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic [4:0]  a1;
        logic [31:0] d1;
        int          t;
    } ent_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic [4:0]  a1;
        logic [31:0] d1;
        int          n;
        logic [4:0]  ea0;
        logic [31:0] ed0;
        logic        el0;
        logic [4:0]  ea1;
        logic [31:0] ed1;
        int          eret;
    } vec_t;

    ent_t mq[$];
    int   sub, retire_m, drop_m, ecnt;
    int   checks, errors;
    vec_t vt[5];

    function automatic bit two_rec(input ent_t e);
        return (e.a1 != 5'd0) && (e.a1 != e.a0);
    endfunction

    function automatic int sat(input int x);
        return (x < CntMax) ? x + 1 : x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive, compare against the model, advance the model, cross the edge.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                        input logic [4:0] a0, input logic [31:0] d0,
                        input logic [4:0] a1, input logic [31:0] d1, input logic rdy);
        logic exp_valid, exp_full, two;
        ent_t e;
        rvfi_valid     = v;
        rvfi_pc_rdata  = pc;
        rvfi_insn      = insn;
        rvfi_rd_addr0  = a0;
        rvfi_rd_wdata0 = d0;
        rvfi_rd_addr1  = a1;
        rvfi_rd_wdata1 = d1;
        trc_ready_i    = rdy;
        #1;
        exp_valid = (mq.size() > 0) && (ecnt >= mq[0].t + 2);
        exp_full  = (mq.size() == DEPTH);
        chk("valid", trc_valid_o, exp_valid);
        chk("full", full_o, exp_full);
        chk("retire_cnt", retire_cnt_o, retire_m);
        chk("drop_cnt", drop_cnt_o, drop_m);
        two = 1'b0;
        if (exp_valid) begin
            two = two_rec(mq[0]);
            chk("pc", trc_pc_o, mq[0].pc);
            chk("insn", trc_insn_o, mq[0].insn);
            if (sub == 0) begin
                chk("rd_addr", trc_rd_addr_o, mq[0].a0);
                chk("rd_wdata", trc_rd_wdata_o, mq[0].d0);
                chk("last", trc_last_o, !two);
            end else begin
                chk("rd_addr", trc_rd_addr_o, mq[0].a1);
                chk("rd_wdata", trc_rd_wdata_o, mq[0].d1);
                chk("last", trc_last_o, 1'b1);
            end
`ifdef CV32E40P_RVFI_TRACE_CYCLE_EN
            chk("cycle", trc_cycle_o, 32'(mq[0].t));
`endif
        end
        if (exp_valid && rdy) begin
            if (sub == 0 && two) sub = 1;
            else begin
                void'(mq.pop_front());
                sub = 0;
            end
        end
        if (v) begin
            if (exp_full) drop_m = sat(drop_m);
            else begin
                e = '{pc, insn, a0, d0, a1, d1, ecnt};
                mq.push_back(e);
                retire_m = sat(retire_m);
            end
        end
        @(posedge clk_i);
        #1;
        ecnt++;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, rdy);
    endtask

    // Asynchronous reset assertion mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset(input string nm);
        #1;
        rst_ni      = 1'b0;
        rvfi_valid  = 1'b0;
        trc_ready_i = 1'b0;
        #1;
        chk({nm, "_valid"}, trc_valid_o, 1'b0);
        chk({nm, "_pc"}, trc_pc_o, 32'h0);
        chk({nm, "_insn"}, trc_insn_o, 32'h0);
        chk({nm, "_addr"}, trc_rd_addr_o, 5'd0);
        chk({nm, "_wdata"}, trc_rd_wdata_o, 32'h0);
        chk({nm, "_last"}, trc_last_o, 1'b0);
        chk({nm, "_full"}, full_o, 1'b0);
        chk({nm, "_retire"}, retire_cnt_o, 0);
        chk({nm, "_drop"}, drop_cnt_o, 0);
`ifdef CV32E40P_RVFI_TRACE_CYCLE_EN
        chk({nm, "_cycle"}, trc_cycle_o, 32'h0);
`endif
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        mq.delete();
        sub      = 0;
        retire_m = 0;
        drop_m   = 0;
        ecnt     = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_ni = 1'b0;
        rvfi_valid = 1'b0;
        rvfi_pc_rdata = '0;
        rvfi_insn = '0;
        rvfi_rd_addr0 = '0;
        rvfi_rd_wdata0 = '0;
        rvfi_rd_addr1 = '0;
        rvfi_rd_wdata1 = '0;
        trc_ready_i = 1'b0;

        vt[0] = '{32'h80, 32'h00100093, 5'd1, 32'd1, 5'd0, 32'd0,
                  1, 5'd1, 32'd1, 1'b1, 5'd0, 32'd0, 1};
        vt[1] = '{32'h84, 32'h0042a28b, 5'd5, 32'hDEADBEEF, 5'd6, 32'h104,
                  2, 5'd5, 32'hDEADBEEF, 1'b0, 5'd6, 32'h104, 2};
        vt[2] = '{32'h88, 32'h0042a28b, 5'd5, 32'h1234, 5'd5, 32'h5678,
                  1, 5'd5, 32'h1234, 1'b1, 5'd0, 32'd0, 3};
        vt[3] = '{32'h8c, 32'h00000013, 5'd0, 32'd7, 5'd0, 32'd9,
                  1, 5'd0, 32'd7, 1'b1, 5'd0, 32'd0, 4};
        vt[4] = '{32'h90, 32'h0031a18b, 5'd0, 32'hA5, 5'd3, 32'h9,
                  2, 5'd0, 32'hA5, 1'b0, 5'd3, 32'h9, 5};

        do_reset("rst_init");

        for (int i = 0; i < 5; i++) begin
            step(1'b1, vt[i].pc, vt[i].insn, vt[i].a0, vt[i].d0, vt[i].a1, vt[i].d1, 1'b1);
            idle(1'b1);
            chk("tbl_valid", trc_valid_o, 1'b1);
            chk("tbl_pc", trc_pc_o, vt[i].pc);
            chk("tbl_addr0", trc_rd_addr_o, vt[i].ea0);
            chk("tbl_wdata0", trc_rd_wdata_o, vt[i].ed0);
            chk("tbl_last0", trc_last_o, vt[i].el0);
            chk("tbl_retire", retire_cnt_o, vt[i].eret);
            idle(1'b1);
            if (vt[i].n == 2) begin
                chk("tbl_valid1", trc_valid_o, 1'b1);
                chk("tbl_addr1", trc_rd_addr_o, vt[i].ea1);
                chk("tbl_wdata1", trc_rd_wdata_o, vt[i].ed1);
                chk("tbl_last1", trc_last_o, 1'b1);
                idle(1'b1);
            end
            chk("tbl_done", trc_valid_o, 1'b0);
        end

        // Backpressure: six retires into a stalled four-entry FIFO.
        do_reset("rst_bp");
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'h100 + 32'(4 * i), 32'h13, 5'(i + 1), 32'(i), 5'd0, 32'd0, 1'b0);
            if (i == 3) chk("bp_full4", full_o, 1'b1);
        end
        idle(1'b0);
        idle(1'b0);
        chk("bp_full", full_o, 1'b1);
        chk("bp_retire", retire_cnt_o, 4);
        chk("bp_drop", drop_cnt_o, 2);
        chk("bp_head_pc", trc_pc_o, 32'h100);
        for (int k = 0; k < 12; k++) idle(1'b1);
        chk("bp_drained", trc_valid_o, 1'b0);

        // Full FIFO with a pop and a retire in the same cycle.
        do_reset("rst_fp");
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'h200 + 32'(4 * i), 32'h13, 5'd2, 32'(i), 5'd0, 32'd0, 1'b0);
        chk("fp_full", full_o, 1'b1);
        step(1'b1, 32'h2f0, 32'h13, 5'd2, 32'h77, 5'd0, 32'd0, 1'b1);
        chk("fp_not_full", full_o, 1'b0);
        chk("fp_drop", drop_cnt_o, 1);
        chk("fp_retire", retire_cnt_o, 4);
        chk("fp_next_pc", trc_pc_o, 32'h204);
        for (int k = 0; k < 8; k++) idle(1'b1);

        // Reset while the head entry is on its second record.
        do_reset("rst_md0");
        step(1'b1, 32'h300, 32'h0042a28b, 5'd5, 32'hDEADBEEF, 5'd6, 32'h104, 1'b0);
        step(1'b1, 32'h304, 32'h13, 5'd1, 32'h1, 5'd0, 32'h0, 1'b0);
        step(1'b1, 32'h308, 32'h13, 5'd2, 32'h2, 5'd0, 32'h0, 1'b0);
        chk("md_emit0_addr", trc_rd_addr_o, 5'd5);
        idle(1'b1);
        chk("md_emit1_addr", trc_rd_addr_o, 5'd6);
        chk("md_emit1_last", trc_last_o, 1'b1);
        do_reset("rst_md");
        for (int k = 0; k < 4; k++) begin
            idle(1'b1);
            chk("md_quiet", trc_valid_o, 1'b0);
        end

`ifdef CV32E40P_RVFI_TRACE_CYCLE_EN
        do_reset("rst_cyc");
        for (int k = 0; k < 10; k++) idle(1'b0);
        step(1'b1, 32'h400, 32'h13, 5'd1, 32'h1, 5'd0, 32'h0, 1'b0);
        idle(1'b0);
        step(1'b1, 32'h404, 32'h13, 5'd2, 32'h2, 5'd0, 32'h0, 1'b0);
        for (int k = 13; k < 20; k++) idle(1'b0);
        chk("cyc_first", trc_cycle_o, 32'd10);
        idle(1'b1);
        chk("cyc_second", trc_cycle_o, 32'd12);
        idle(1'b1);
`endif

        // Random traffic against the model.
        do_reset("rst_rand");
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 99) < 60, $urandom, $urandom,
                 5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)), $urandom,
                 $urandom_range(0, 99) < 55);
        end
        for (int k = 0; k < 12; k++) idle(1'b1);
        chk("rand_drained", trc_valid_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
